dest_ip_tbl_ctrl: RTL and testbench

- Initiator side of the destination-IP exception-table access interface (tbl_rd_req/tbl_wr_req with 1-cycle ack).
- Accepts single read/write commands, or a clear-all command, from the register block.
- Issues one-cycle request pulses to the table owner and waits for the matching ack, with a timeout.
- Returns read data and an error flag to the register block; sits between the AXI-Lite register decode and the output-port-lookup table.

---
 rtl/dest_ip_tbl_ctrl.sv | 147 ++++++++++++++
 tb/tb_dest_ip_tbl_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_ip_tbl_ctrl.sv
// Initiator for the destination-IP exception table: issues single read/write
// or clear-all request pulses, waits for the matching ack with a timeout.
module dest_ip_tbl_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH         = 5,
    parameter int DEPTH              = 32,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_RESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic                          cmd_clear_all,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                          rsp_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [31:0]                   timeout_count,
    output logic                          tbl_rd_req,
    output logic                          tbl_wr_req,
    output logic [ADDR_WIDTH-1:0]         tbl_rd_addr,
    output logic [ADDR_WIDTH-1:0]         tbl_wr_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    input  logic                          tbl_rd_ack,
    input  logic                          tbl_wr_ack
);

    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0]  LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   index;
    logic [TIMER_WIDTH-1:0]  timer;
    logic                    op_wr;
    logic                    op_clear;
    logic                    advance;
    logic                    ack_match;
    logic                    last_entry;
    logic                    timer_expired;

    assign cmd_ready     = (state == IDLE);
    assign ack_match     = op_wr ? tbl_wr_ack : tbl_rd_ack;
    assign last_entry    = (index == LAST_INDEX);
    assign timer_expired = (timer == TIMER_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) state <= IDLE;
        else           state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (cmd_valid) next_state = ISSUE;
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (advance)            next_state = ISSUE;
                else if (ack_match)     next_state = (op_clear && !last_entry) ? WAIT : RESP;
                else if (timer_expired) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request pulses are launched on the edge that enters ISSUE, so they line up with it.
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            index         <= '0;
            timer         <= '0;
            op_wr         <= 1'b0;
            op_clear      <= 1'b0;
            advance       <= 1'b0;
            busy          <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= '0;
            timeout_count <= '0;
            tbl_rd_req    <= 1'b0;
            tbl_wr_req    <= 1'b0;
            tbl_rd_addr   <= '0;
            tbl_wr_addr   <= '0;
            tbl_wr_data   <= '0;
        end else begin
            tbl_rd_req <= 1'b0;
            tbl_wr_req <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            busy       <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_wr    <= cmd_write | cmd_clear_all;
                        op_clear <= cmd_clear_all;
                        index    <= cmd_clear_all ? '0 : cmd_addr;
                        if (cmd_write || cmd_clear_all) begin
                            tbl_wr_req  <= 1'b1;
                            tbl_wr_addr <= cmd_clear_all ? '0 : cmd_addr;
                            tbl_wr_data <= cmd_clear_all ? '0 : cmd_wdata;
                        end else begin
                            tbl_rd_req  <= 1'b1;
                            tbl_rd_addr <= cmd_addr;
                        end
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    // Clear-all spends one idle cycle stepping the index before the next pulse.
                    if (advance) begin
                        advance     <= 1'b0;
                        tbl_wr_req  <= 1'b1;
                        tbl_wr_addr <= index;
                        tbl_wr_data <= '0;
                    end else if (ack_match) begin
                        if (op_clear && !last_entry) begin
                            index   <= index + 1'b1;
                            advance <= 1'b1;
                        end else begin
                            rsp_valid <= 1'b1;
                            if (!op_wr) rsp_rdata <= tbl_rd_data;
                        end
                    end else if (timer_expired) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        if (timeout_count != 32'hFFFF_FFFF) timeout_count <= timeout_count + 32'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dest_ip_tbl_ctrl.sv
// Self-checking bench for dest_ip_tbl_ctrl: table of single commands plus
// clear-all, timeout and abort-by-reset sequences against a table responder.
module tb_dest_ip_tbl_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int TO    = 16;

    logic          AXI_ACLK  = 1'b0;
    logic          AXI_RESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic          cmd_clear_all = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic [31:0]   timeout_count;
    logic          tbl_rd_req;
    logic          tbl_wr_req;
    logic [AW-1:0] tbl_rd_addr;
    logic [AW-1:0] tbl_wr_addr;
    logic [DW-1:0] tbl_wr_data;
    logic [DW-1:0] tbl_rd_data;
    logic          tbl_rd_ack;
    logic          tbl_wr_ack;

    always #5 AXI_ACLK = ~AXI_ACLK;

    dest_ip_tbl_ctrl #(
        .C_S_AXI_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .AXI_ACLK(AXI_ACLK), .AXI_RESET(AXI_RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_clear_all(cmd_clear_all), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .timeout_count(timeout_count),
        .tbl_rd_req(tbl_rd_req), .tbl_wr_req(tbl_wr_req),
        .tbl_rd_addr(tbl_rd_addr), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
        .tbl_rd_data(tbl_rd_data), .tbl_rd_ack(tbl_rd_ack), .tbl_wr_ack(tbl_wr_ack)
    );

    // Table owner model: 1-cycle acks, optional ack suppression and stray acks.
    logic [DW-1:0] mem [DEPTH] = '{default: '0};
    logic          rd_ack_q  = 1'b0;
    logic          wr_ack_q  = 1'b0;
    logic [DW-1:0] rd_data_q = '0;
    logic          rd_en     = 1'b1;
    logic          wr_en     = 1'b1;
    logic          stray_rd  = 1'b0;
    logic          stray_wr  = 1'b0;
    int            wr_ack_limit = DEPTH;

    always @(posedge AXI_ACLK) begin
        rd_ack_q  <= tbl_rd_req && rd_en;
        rd_data_q <= mem[tbl_rd_addr];
        wr_ack_q  <= tbl_wr_req && wr_en && (int'(tbl_wr_addr) < wr_ack_limit);
        if (tbl_wr_req && wr_en && (int'(tbl_wr_addr) < wr_ack_limit))
            mem[tbl_wr_addr] <= tbl_wr_data;
    end

    assign tbl_rd_ack  = rd_ack_q | stray_rd;
    assign tbl_wr_ack  = wr_ack_q | stray_wr;
    assign tbl_rd_data = rd_data_q;

    int cyc = 0;
    always @(posedge AXI_ACLK) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } req_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    req_t wr_log[$];
    req_t rd_log[$];
    rsp_t sb[$];
    rsp_t mon_exp;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   rsp_cnt = 0;
    int   exp_to  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: logs request pulses and scores every response against the queue.
    always @(negedge AXI_ACLK) begin
        if (tbl_wr_req) wr_log.push_back('{tbl_wr_addr, tbl_wr_data, cyc});
        if (tbl_rd_req) rd_log.push_back('{tbl_rd_addr, '0, cyc});
        if (rsp_valid) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h err=%0b with nothing outstanding",
                         rsp_rdata, rsp_err);
            end else begin
                mon_exp = sb.pop_front();
                check("rsp_rdata", rsp_rdata, mon_exp.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_exp.err});
            end
        end
    end

    task automatic run_cmd(input string name, input logic w, input logic c,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] er, input logic ee,
                           input int exp_delay, input int exp_low, output int t0);
        int low;
        int rsp_c;
        bit got;
        bit done;
        low = 0; rsp_c = -1; got = 1'b0; done = 1'b0;
        if (ee) exp_to++;
        @(negedge AXI_ACLK);
        check({name, "_ready_before"}, {31'd0, cmd_ready}, 32'd1);
        wr_log.delete();
        rd_log.delete();
        cmd_valid = 1'b1; cmd_write = w; cmd_clear_all = c; cmd_addr = a; cmd_wdata = d;
        sb.push_back('{er, ee});
        @(posedge AXI_ACLK);
        #1;
        cmd_valid = 1'b0;
        t0 = cyc;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge AXI_ACLK);
            if (!cmd_ready) low++;
            if (rsp_valid && !got) begin
                got   = 1'b1;
                rsp_c = cyc;
            end
            if (cmd_ready) done = 1'b1;
        end
        check({name, "_completed"}, {31'd0, done}, 32'd1);
        check({name, "_rsp_delay"}, rsp_c - t0, exp_delay);
        check({name, "_ready_low"}, low, exp_low);
        check({name, "_timeout_count"}, timeout_count, exp_to);
    endtask

    typedef struct {
        logic          w;
        logic          c;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rd_en;
        logic          wr_en;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_delay;
        int            exp_low;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    t0;
        int    cnt0;
        int    ridx[3];
        string nm;

        vecs[0] = '{1'b1, 1'b0, 5'd3,  32'h0A00_0001, 1'b1, 1'b1, 32'h0,           1'b0, 2,  3};
        vecs[1] = '{1'b0, 1'b0, 5'd3,  32'h0,         1'b1, 1'b1, 32'h0A00_0001,   1'b0, 2,  3};
        vecs[2] = '{1'b1, 1'b0, 5'd0,  32'h1111_1111, 1'b1, 1'b1, 32'h0,           1'b0, 2,  3};
        vecs[3] = '{1'b1, 1'b0, 5'd31, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0,           1'b0, 2,  3};
        vecs[4] = '{1'b0, 1'b0, 5'd31, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF,   1'b0, 2,  3};
        vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 32'h1111_1111,   1'b0, 2,  3};
        vecs[6] = '{1'b0, 1'b0, 5'd7,  32'h0,         1'b0, 1'b1, 32'h0,           1'b1, 17, 18};
        vecs[7] = '{1'b1, 1'b0, 5'd9,  32'h0000_0099, 1'b1, 1'b0, 32'h0,           1'b1, 17, 18};
        vecs[8] = '{1'b0, 1'b0, 5'd3,  32'h0,         1'b1, 1'b0, 32'h0A00_0001,   1'b0, 2,  3};

        // Reset state.
        repeat (3) @(negedge AXI_ACLK);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_reqs", {30'd0, tbl_rd_req, tbl_wr_req}, 32'd0);
        check("rst_rsp", {31'd0, rsp_valid | rsp_err}, 32'd0);
        check("rst_timeout_count", timeout_count, 32'd0);
        AXI_RESET = 1'b0;
        @(negedge AXI_ACLK);
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            nm    = $sformatf("vec%0d", i);
            rd_en = vecs[i].rd_en;
            wr_en = vecs[i].wr_en;
            run_cmd(nm, vecs[i].w, 1'b0, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_delay, vecs[i].exp_low, t0);
            check({nm, "_wr_pulses"}, wr_log.size(), vecs[i].w ? 32'd1 : 32'd0);
            check({nm, "_rd_pulses"}, rd_log.size(), vecs[i].w ? 32'd0 : 32'd1);
            if (vecs[i].w && wr_log.size() > 0) begin
                check({nm, "_wr_addr"}, {27'd0, wr_log[0].addr}, {27'd0, vecs[i].addr});
                check({nm, "_wr_data"}, wr_log[0].data, vecs[i].wdata);
                check({nm, "_wr_cyc"}, wr_log[0].cyc, t0);
            end
            if (!vecs[i].w && rd_log.size() > 0) begin
                check({nm, "_rd_addr"}, {27'd0, rd_log[0].addr}, {27'd0, vecs[i].addr});
                check({nm, "_rd_cyc"}, rd_log[0].cyc, t0);
            end
        end

        // Fill every entry, then clear-all (address input must be ignored).
        rd_en = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            run_cmd("preload", 1'b1, 1'b0, AW'(i), 32'h100 + i, 32'h0, 1'b0, 2, 3, t0);
        run_cmd("clear_all", 1'b0, 1'b1, 5'd17, 32'hFFFF_FFFF, 32'h0, 1'b0, 95, 96, t0);
        check("clear_wr_pulses", wr_log.size(), DEPTH);
        check("clear_rd_pulses", rd_log.size(), 32'd0);
        for (int i = 0; i < DEPTH && i < wr_log.size(); i++) begin
            check($sformatf("clear_addr%0d", i), {27'd0, wr_log[i].addr}, i);
            check($sformatf("clear_data%0d", i), wr_log[i].data, 32'd0);
            check($sformatf("clear_cyc%0d", i), wr_log[i].cyc, t0 + 3 * i);
        end
        ridx = '{0, 17, 31};
        for (int i = 0; i < 3; i++)
            run_cmd($sformatf("read_cleared%0d", ridx[i]), 1'b0, 1'b0, AW'(ridx[i]),
                    32'h0, 32'h0, 1'b0, 2, 3, t0);

        // Clear-all whose responder stops acking at index 5.
        wr_ack_limit = 5;
        run_cmd("clear_stall", 1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b1, 32, 33, t0);
        check("clear_stall_pulses", wr_log.size(), 32'd6);
        if (wr_log.size() > 0)
            check("clear_stall_last_addr", {27'd0, wr_log[wr_log.size()-1].addr}, 32'd5);
        wr_ack_limit = DEPTH;

        // Acks while idle are ignored.
        cnt0 = rsp_cnt;
        @(negedge AXI_ACLK);
        stray_rd = 1'b1;
        stray_wr = 1'b1;
        repeat (2) @(negedge AXI_ACLK);
        stray_rd = 1'b0;
        stray_wr = 1'b0;
        check("idle_ack_busy", {31'd0, busy}, 32'd0);
        check("idle_ack_reqs", {30'd0, tbl_rd_req, tbl_wr_req}, 32'd0);
        repeat (2) @(negedge AXI_ACLK);
        check("idle_ack_no_rsp", rsp_cnt, cnt0);

        run_cmd("write_5a", 1'b1, 1'b0, 5'd3, 32'h5A5A_5A5A, 32'h0, 1'b0, 2, 3, t0);

        // Read in flight, stray write ack, then reset before the read ack.
        rd_en = 1'b0;
        cnt0  = rsp_cnt;
        @(negedge AXI_ACLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_clear_all = 1'b0; cmd_addr = 5'd3;
        @(posedge AXI_ACLK);
        #1;
        cmd_valid = 1'b0;
        @(negedge AXI_ACLK);
        check("abort_rd_req", {31'd0, tbl_rd_req}, 32'd1);
        @(negedge AXI_ACLK);
        stray_wr = 1'b1;
        @(negedge AXI_ACLK);
        stray_wr = 1'b0;
        check("abort_busy_after_stray", {31'd0, busy}, 32'd1);
        @(negedge AXI_ACLK);
        #2;
        AXI_RESET = 1'b1;
        #1;
        check("abort_rst_busy", {31'd0, busy}, 32'd0);
        check("abort_rst_reqs", {30'd0, tbl_rd_req, tbl_wr_req}, 32'd0);
        check("abort_rst_rsp", {31'd0, rsp_valid | rsp_err}, 32'd0);
        check("abort_rst_rdata", rsp_rdata, 32'd0);
        check("abort_rst_timeout_count", timeout_count, 32'd0);
        check("abort_rst_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge AXI_ACLK);
        AXI_RESET = 1'b0;
        exp_to    = 0;
        rd_en     = 1'b1;
        repeat (2) @(negedge AXI_ACLK);
        check("abort_no_rsp", rsp_cnt, cnt0);
        run_cmd("read_after_reset", 1'b0, 1'b0, 5'd3, 32'h0, 32'h5A5A_5A5A, 1'b0, 2, 3, t0);
        check("read_after_reset_pulses", rd_log.size(), 32'd1);

        repeat (2) @(negedge AXI_ACLK);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
